// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_pkg
// Brief   : Shared types and field-offset constants for the decode/execute
//           pipeline register (control bundle, state encoding, word slots).
// Revision: 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Decoded control bundle carried alongside the datapath words.
  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] aluctrl;
    logic       alusrc;
    logic [1:0] pcsrc;
    logic       jalr;
  } ctrl_t;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // Word-slot indices inside the data bus {rd1, rd2, pc, immext, pcplus4};
  // slot k occupies bits [k*WIDTH +: WIDTH].
  localparam int unsigned C_DATA_PCPLUS4 = 0;
  localparam int unsigned C_DATA_IMMEXT  = 1;
  localparam int unsigned C_DATA_PC      = 2;
  localparam int unsigned C_DATA_RD2     = 3;
  localparam int unsigned C_DATA_RD1     = 4;
  localparam int unsigned C_DATA_WORDS   = 5;

  // Field-slot indices inside the register bus {rs1, rs2, rd}.
  localparam int unsigned C_REG_RD    = 0;
  localparam int unsigned C_REG_RS2   = 1;
  localparam int unsigned C_REG_RS1   = 2;
  localparam int unsigned C_REG_WORDS = 3;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module  : pipe_perf_cnt
// Brief   : Free-running event counter, +1 per cycle with inc_i high,
//           wraps at 2^CNTW.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_perf_cnt #(
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_i,
  output logic [CNTW-1:0] cnt_o
);

  logic [CNTW-1:0] cnt_q;

  // Count qualifying cycles; natural overflow provides the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule : pipe_perf_cnt
`default_nettype wire

// File: rtl/decode_execute_pipe.sv
`default_nettype none
// ============================================================================
// Module  : decode_execute_pipe
// Brief   : Decode->execute pipeline register built as a two-entry skid
//           buffer (main + skid). Main always drives the outputs; in_ready
//           is registered so out_ready never reaches in_ready in one cycle.
//           Optional macro PIPE_PERF_EN adds stall/flush counters; without
//           it both counter outputs are tied to zero.
// Revision: 1.0 - initial release
// ============================================================================
module decode_execute_pipe
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGW  = 5,
  parameter int unsigned CNTW  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  ctrl_t                        in_ctrl,
  input  logic [C_DATA_WORDS*WIDTH-1:0] in_data,
  input  logic [C_REG_WORDS*REGW-1:0]   in_regs,
  output logic                         out_valid,
  input  logic                         out_ready,
  output ctrl_t                        out_ctrl,
  output logic [C_DATA_WORDS*WIDTH-1:0] out_data,
  output logic [C_REG_WORDS*REGW-1:0]   out_regs,
  output logic [CNTW-1:0]              stall_cnt,
  output logic [CNTW-1:0]              flush_cnt
);

  localparam int unsigned C_DW = C_DATA_WORDS * WIDTH;
  localparam int unsigned C_RW = C_REG_WORDS * REGW;

  pipe_state_e      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  ctrl_t            main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [C_DW-1:0]  main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [C_RW-1:0]  main_regs_q, main_regs_d, skid_regs_q, skid_regs_d;
  logic             in_xfer, out_xfer;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  // Next-state and entry movement; flush overrides every other event.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    main_regs_d = main_regs_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    skid_regs_d = skid_regs_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d     = ST_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            main_regs_d = in_regs;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            main_regs_d = in_regs;
          end else if (in_xfer) begin
            state_d     = ST_FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            skid_regs_d = in_regs;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            state_d     = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            main_regs_d = skid_regs_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  // State, ready flag and both entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      main_regs_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_regs_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      main_regs_q <= main_regs_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_regs_q <= skid_regs_d;
    end
  end

  // Stale control must never leak a regwrite/memwrite when nothing is held.
  assign out_ctrl = out_valid ? main_ctrl_q : '0;
  assign out_data = main_data_q;
  assign out_regs = main_regs_q;

`ifdef PIPE_PERF_EN
  pipe_perf_cnt #(.CNTW(CNTW)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (out_valid & ~out_ready),
    .cnt_o (stall_cnt)
  );

  pipe_perf_cnt #(.CNTW(CNTW)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (flush_i),
    .cnt_o (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule : decode_execute_pipe
`default_nettype wire

// File: tb/tb_decode_execute_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_decode_execute_pipe
// Brief   : Directed and randomized checks for decode_execute_pipe.
// Revision: 1.0 - initial release
// ============================================================================
module tb_decode_execute_pipe;
  import pipe_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 32;
`ifdef PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush_i;
  logic            in_valid;
  logic            in_ready;
  ctrl_t           in_ctrl;
  logic [5*W-1:0]  in_data;
  logic [3*RW-1:0] in_regs;
  logic            out_valid;
  logic            out_ready;
  ctrl_t           out_ctrl;
  logic [5*W-1:0]  out_data;
  logic [3*RW-1:0] out_regs;
  logic [CW-1:0]   stall_cnt;
  logic [CW-1:0]   flush_cnt;

  int checks = 0;
  int errors = 0;

  decode_execute_pipe #(.WIDTH(W), .REGW(RW), .CNTW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .in_regs   (in_regs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_regs  (out_regs),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [5*W-1:0] mk_data(input logic [31:0] pc);
    return {pc + 32'h1000, pc + 32'h2000, pc, pc + 32'h3000, pc + 32'd4};
  endfunction

  function automatic ctrl_t mk_ctrl(input logic [31:0] pc);
    ctrl_t c;
    c.regwrite  = 1'b1;
    c.resultsrc = pc[3:2];
    c.memwrite  = pc[4];
    c.opcode    = 7'h33;
    c.funct3    = pc[7:5];
    c.aluctrl   = pc[11:8];
    c.alusrc    = 1'b1;
    c.pcsrc     = 2'b00;
    c.jalr      = 1'b0;
    return c;
  endfunction

  function automatic logic [3*RW-1:0] mk_regs(input logic [31:0] pc);
    return pc[16:2];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_data  = mk_data(pc);
    in_ctrl  = mk_ctrl(pc);
    in_regs  = mk_regs(pc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush_i = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0);
    #3;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_ctrl !== '0 || out_data !== '0 || out_regs !== '0) begin
      errors++; $display("FAIL rst_outputs ctrl %h data %h regs %h exp 0", out_ctrl, out_data, out_regs); end
    checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++; $display("FAIL rst_counters stall %0d flush %0d exp 0", stall_cnt, flush_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 32'h100);
    tick();
    drive(1'b0, 32'h0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== mk_data(32'h100)) begin errors++; $display("FAIL basic_data got %h exp %h", out_data, mk_data(32'h100)); end
    checks++; if (out_regs !== mk_regs(32'h100)) begin errors++; $display("FAIL basic_regs got %h exp %h", out_regs, mk_regs(32'h100)); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h100); tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %b exp 1", in_ready); end
    drive(1'b1, 32'h104); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b exp 0", in_ready); end
    drive(1'b1, 32'h108); tick();
    checks++; if (in_ready !== 1'b0 || out_data !== mk_data(32'h100)) begin
      errors++; $display("FAIL bp_hold ready %b data %h exp 0 / %h", in_ready, out_data, mk_data(32'h100)); end
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b1 || out_data !== mk_data(32'h100)) begin
      errors++; $display("FAIL bp_out0 valid %b data %h exp 1 / %h", out_valid, out_data, mk_data(32'h100)); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== mk_data(32'h104)) begin
      errors++; $display("FAIL bp_out1 valid %b data %h exp 1 / %h", out_valid, out_data, mk_data(32'h104)); end
    tick();
    drive(1'b0, 32'h0);
    checks++; if (out_valid !== 1'b1 || out_data !== mk_data(32'h108)) begin
      errors++; $display("FAIL bp_out2 valid %b data %h exp 1 / %h", out_valid, out_data, mk_data(32'h108)); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h100); tick();
    drive(1'b1, 32'h104); tick();
    drive(1'b1, 32'h200);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(1'b0, 32'h0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL flush_ctrl got %h exp 0", out_ctrl); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", in_ready); end
    checks++; if (flush_cnt !== (PERF ? CW'(1) : CW'(0))) begin
      errors++; $display("FAIL flush_cnt got %0d exp %0d", flush_cnt, PERF ? 1 : 0); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_no_emit cycle %0d valid %b data %h exp 0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h300); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== mk_data(32'h300) ||
                    out_ctrl !== mk_ctrl(32'h300) || out_regs !== mk_regs(32'h300)) begin
        errors++; $display("FAIL stall_stable cycle %0d valid %b data %h ctrl %h", i, out_valid, out_data, out_ctrl); end
    end
    checks++; if (stall_cnt !== (PERF ? CW'(5) : CW'(0))) begin
      errors++; $display("FAIL stall_cnt got %0d exp %0d", stall_cnt, PERF ? 5 : 0); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h400); tick();
    drive(1'b1, 32'h404); tick();
    drive(1'b0, 32'h0);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL areset_pre ready %b valid %b exp 0 / 1", in_ready, out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL areset_flags valid %b ready %b exp 0 / 0", out_valid, in_ready); end
    checks++; if (out_ctrl !== '0 || out_data !== '0 || out_regs !== '0) begin
      errors++; $display("FAIL areset_outputs ctrl %h data %h regs %h exp 0", out_ctrl, out_data, out_regs); end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL areset_after valid %b ready %b exp 0 / 1", out_valid, in_ready); end
  endtask

  task automatic test_random();
    logic [31:0]    q[$];
    logic [31:0]    next_pc;
    logic           iv, ordy, exp_valid, exp_ready, stalled_prev;
    logic [5*W-1:0] prev_data;
    ctrl_t          prev_ctrl;
    int             prints;
    do_reset();
    next_pc = 32'h1000;
    stalled_prev = 1'b0;
    prev_data = '0;
    prev_ctrl = '0;
    prints = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      exp_valid = (q.size() > 0);
      exp_ready = (q.size() < 2);
      checks++; if (out_valid !== exp_valid || in_ready !== exp_ready) begin
        errors++; if (prints++ < 20) $display("FAIL rnd_flags cyc %0d valid %b ready %b exp %b / %b", cyc, out_valid, in_ready, exp_valid, exp_ready); end
      if (stalled_prev) begin
        checks++; if (out_data !== prev_data || out_ctrl !== prev_ctrl) begin
          errors++; if (prints++ < 20) $display("FAIL rnd_stable cyc %0d data %h exp %h", cyc, out_data, prev_data); end
      end
      if (!exp_valid) begin
        checks++; if (out_ctrl !== '0) begin
          errors++; if (prints++ < 20) $display("FAIL rnd_ctrl_zero cyc %0d got %h exp 0", cyc, out_ctrl); end
      end
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      drive(iv, next_pc);
      out_ready = ordy;
      if (exp_valid && ordy) begin
        checks++; if (out_data !== mk_data(q[0]) || out_ctrl !== mk_ctrl(q[0]) || out_regs !== mk_regs(q[0])) begin
          errors++; if (prints++ < 20) $display("FAIL rnd_order cyc %0d data %h exp %h", cyc, out_data, mk_data(q[0])); end
        void'(q.pop_front());
      end
      if (iv && exp_ready) begin
        q.push_back(next_pc);
        next_pc = next_pc + 32'd4;
      end
      stalled_prev = exp_valid && !ordy;
      prev_data = out_data;
      prev_ctrl = out_ctrl;
      tick();
    end
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== mk_data(q[0])) begin
        errors++; $display("FAIL rnd_drain valid %b data %h exp 1 / %h", out_valid, out_data, mk_data(q[0])); end
      void'(q.pop_front());
      tick();
    end
    checks++; if (out_valid !== 1'b0 || q.size() != 0) begin
      errors++; $display("FAIL rnd_final valid %b left %0d exp 0 / 0", out_valid, q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_stall();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_decode_execute_pipe
`default_nettype wire
